// File: rtl/tdm_selector41.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_selector41
//  Purpose  : Transmit end of a 4-channel time-division link. Merges four
//             independent producer channels onto one shared data word using
//             a round-robin arbiter and a single output holding register.
//             Each word is tagged with its channel index on oS1/oS0 so the
//             downstream 1-to-4 de-selector can route it back.
//  Ports    : iClk            - system clock, rising edge
//             iRst_n          - asynchronous active-low reset
//             iD0..iD3        - channel data words (WIDTH bits)
//             iValid[3:0]     - per-channel request
//             oReady[3:0]     - per-channel grant (one-hot or zero)
//             oZ              - merged data word
//             oS1/oS0         - channel index of the word on oZ
//             oValid          - oZ/oS1/oS0 hold a word
//             iReady          - downstream accepts the word this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_selector41 #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [WIDTH-1:0] iD0,
    input  logic [WIDTH-1:0] iD1,
    input  logic [WIDTH-1:0] iD2,
    input  logic [WIDTH-1:0] iD3,
    input  logic [3:0]       iValid,
    output logic [3:0]       oReady,
    output logic [WIDTH-1:0] oZ,
    output logic             oS1,
    output logic             oS0,
    output logic             oValid,
    input  logic             iReady
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [1:0]       r_ptr;
    logic             w_slotFree;
    logic             w_found;
    logic [1:0]       w_grantIdx;
    logic             w_grantEn;
    logic [WIDTH-1:0] w_grantData;

    assign oValid = (r_state == ST_HOLD);

    // The holding register can take a new word when empty, or when the
    // current word leaves this same cycle (no-bubble reload).
    assign w_slotFree = (r_state == ST_IDLE) || (oValid && iReady);

    // Round-robin scan starting at r_ptr. The loop runs from the farthest
    // offset down to zero so the nearest requester is the last assignment
    // and therefore wins.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (iValid[r_ptr + 2'(i)]) begin
                w_found    = 1'b1;
                w_grantIdx = r_ptr + 2'(i);
            end
        end
    end

    // Gating with iRst_n keeps oReady low for the whole reset interval,
    // not only after the next edge.
    assign w_grantEn = w_slotFree && w_found && iRst_n;

    always_comb begin
        oReady = 4'b0000;
        if (w_grantEn) begin
            oReady[w_grantIdx] = 1'b1;
        end
    end

    always_comb begin
        case (w_grantIdx)
            2'd0:    w_grantData = iD0;
            2'd1:    w_grantData = iD1;
            2'd2:    w_grantData = iD2;
            default: w_grantData = iD3;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_stateNext = r_state;
        if (w_grantEn) begin
            w_stateNext = ST_HOLD;
        end else if (oValid && iReady) begin
            w_stateNext = ST_IDLE;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Holding register and round-robin pointer; oZ/oS keep their last value
    // when the word drains without a replacement.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oZ    <= '0;
            oS1   <= 1'b0;
            oS0   <= 1'b0;
            r_ptr <= 2'd0;
        end else if (w_grantEn) begin
            oZ    <= w_grantData;
            oS1   <= w_grantIdx[1];
            oS0   <= w_grantIdx[0];
            r_ptr <= w_grantIdx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_selector41.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_selector41
//  Purpose  : Self-checking bench for tdm_selector41. A behavioural model of
//             the link (held word, index, fairness pointer) predicts outputs
//             each cycle; literal expectations pin the model at key points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_selector41;

    localparam int c_WIDTH = 8;

    logic               iClk = 1'b0;
    logic               iRst_n;
    logic [c_WIDTH-1:0] iD0, iD1, iD2, iD3;
    logic [3:0]         iValid;
    logic [3:0]         oReady;
    logic [c_WIDTH-1:0] oZ;
    logic               oS1, oS0, oValid;
    logic               iReady;

    int vectors = 0;
    int errs    = 0;

    // Model state
    logic               mValid;
    logic [c_WIDTH-1:0] mZ;
    logic [1:0]         mIdx;
    int                 mPtr;

    always #5 iClk = ~iClk;

    tdm_selector41 #(.WIDTH(c_WIDTH)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iD0    (iD0),
        .iD1    (iD1),
        .iD2    (iD2),
        .iD3    (iD3),
        .iValid (iValid),
        .oReady (oReady),
        .oZ     (oZ),
        .oS1    (oS1),
        .oS0    (oS0),
        .oValid (oValid),
        .iReady (iReady)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [c_WIDTH-1:0] chanData(input int k);
        case (k)
            0:       return iD0;
            1:       return iD1;
            2:       return iD2;
            default: return iD3;
        endcase
    endfunction

    // Which channel the link should serve now: -1 when nobody is granted.
    function automatic int modelGrant();
        if (iRst_n !== 1'b1) return -1;
        if (mValid && !iReady) return -1;
        for (int i = 0; i < 4; i++) begin
            if (iValid[(mPtr + i) % 4]) return (mPtr + i) % 4;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mValid = 1'b0;
        mZ     = '0;
        mIdx   = 2'd0;
        mPtr   = 0;
    endtask

    // One clock: compare at the falling edge, advance the model on the
    // rising edge, return 1 ns after it.
    task automatic cycle();
        int g;
        logic [3:0] expReady;
        @(negedge iClk);
        g = modelGrant();
        expReady = (g < 0) ? 4'b0000 : (4'b0001 << g);
        chk("oReady", 32'(oReady), 32'(expReady));
        chk("oValid", 32'(oValid), 32'(mValid));
        chk("oZ", 32'(oZ), 32'(mZ));
        chk("index", 32'({oS1, oS0}), 32'(mIdx));
        @(posedge iClk);
        if (iRst_n === 1'b1) begin
            if (g >= 0) begin
                mZ     = chanData(g);
                mIdx   = 2'(g);
                mValid = 1'b1;
                mPtr   = (g + 1) % 4;
            end else if (mValid && iReady) begin
                mValid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic doReset();
        iRst_n = 1'b0;
        modelReset();
        cycle();
        cycle();
        iRst_n = 1'b1;
    endtask

    logic [7:0] rrSeq [6];
    logic [3:0] desel;

    initial begin
        rrSeq[0] = 8'h11; rrSeq[1] = 8'h22; rrSeq[2] = 8'h33;
        rrSeq[3] = 8'h44; rrSeq[4] = 8'h11; rrSeq[5] = 8'h22;

        iD0 = '0; iD1 = '0; iD2 = '0; iD3 = '0;
        iValid = 4'b0000;
        iReady = 1'b0;
        iRst_n = 1'b1;
        modelReset();
        #2;

        // Reset then idle; requests during reset must not be granted
        iRst_n = 1'b0;
        #1;
        chk("rst_oValid", 32'(oValid), 32'd0);
        chk("rst_oZ", 32'(oZ), 32'd0);
        iValid = 4'b1111;
        #1;
        chk("rst_oReady", 32'(oReady), 32'd0);
        cycle();
        cycle();
        iValid = 4'b0000;
        iRst_n = 1'b1;
        cycle();
        cycle();

        // Single channel
        iValid = 4'b0010; iD1 = 8'hA5; iReady = 1'b1;
        cycle();
        iValid = 4'b0000;
        chk("single_oZ", 32'(oZ), 32'h0A5);
        chk("single_idx", 32'({oS1, oS0}), 32'd1);
        chk("single_oValid", 32'(oValid), 32'd1);
        cycle();
        chk("single_drain", 32'(oValid), 32'd0);
        chk("single_keep_oZ", 32'(oZ), 32'h0A5);

        // Round robin with wrap from pointer 0
        doReset();
        iD0 = 8'h11; iD1 = 8'h22; iD2 = 8'h33; iD3 = 8'h44;
        iValid = 4'b1111; iReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_oZ", 32'(oZ), 32'(rrSeq[i]));
            chk("rr_idx", 32'({oS1, oS0}), 32'(i % 4));
            chk("rr_oValid", 32'(oValid), 32'd1);
        end

        // Back-pressure on a channel-2 word
        iD2 = 8'h3C;
        cycle();
        chk("bp_load", 32'(oZ), 32'h03C);
        iReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_oZ", 32'(oZ), 32'h03C);
            chk("bp_idx", 32'({oS1, oS0}), 32'd2);
        end
        iReady = 1'b1;
        cycle();
        chk("bp_next_idx", 32'({oS1, oS0}), 32'd3);
        chk("bp_next_oZ", 32'(oZ), 32'h044);

        // Asynchronous reset between edges while holding 0x44
        #2;
        iRst_n = 1'b0;
        #1;
        modelReset();
        chk("arst_oValid", 32'(oValid), 32'd0);
        chk("arst_oZ", 32'(oZ), 32'd0);
        chk("arst_idx", 32'({oS1, oS0}), 32'd0);
        chk("arst_oReady", 32'(oReady), 32'd0);
        cycle();
        iRst_n = 1'b1;
        #1;
        chk("arst_first_grant", 32'(oReady), 32'h1);
        cycle();
        chk("arst_first_oZ", 32'(oZ), 32'h011);

        // Loopback through a de-selector: bit 0 of the word routed by index
        iD0 = 8'h00; iD1 = 8'h00; iD2 = 8'h00; iD3 = 8'h00;
        for (int ch = 0; ch < 4; ch++) begin
            iValid = 4'b0000;
            cycle();
            cycle();
            case (ch)
                0: iD0 = 8'h01;
                1: iD1 = 8'h01;
                2: iD2 = 8'h01;
                default: iD3 = 8'h01;
            endcase
            iValid = 4'b0001 << ch;
            cycle();
            iValid = 4'b0000;
            desel = 4'b0000;
            if (oValid) desel[{oS1, oS0}] = oZ[0];
            chk("loopback", 32'(desel), 32'(4'b0001 << ch));
            iD0 = 8'h00; iD1 = 8'h00; iD2 = 8'h00; iD3 = 8'h00;
        end
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_selector41.md
Name: tdm_selector41

Overview:
- Transmit end of the 4-channel time-division link whose receive end is the 1-to-4 de-selector.
- Takes four independent producer channels and merges them onto one shared data word.
- Each word is tagged with select lines iS1/iS0-compatible (oS1, oS0), so the downstream de-selector can route it back to outputs 0..3.
- Uses a round-robin arbiter, a single output holding register and a valid/ready handshake on every channel and on the output.

Parameters:
- WIDTH, 8, data width of each channel and of oZ.

Ports:
- iClk  input  1  system clock, all state changes on rising edge
- iRst_n  input  1  asynchronous active-low reset
- iD0  input  WIDTH  channel 0 data
- iD1  input  WIDTH  channel 1 data
- iD2  input  WIDTH  channel 2 data
- iD3  input  WIDTH  channel 3 data
- iValid  input  4  per-channel request, bit k = channel k has a word
- oReady  output  4  per-channel grant, bit k = channel k word consumed this cycle
- oZ  output  WIDTH  merged data word
- oS1  output  1  channel index MSB of the word on oZ
- oS0  output  1  channel index LSB of the word on oZ
- oValid  output  1  oZ/oS1/oS0 hold a word
- iReady  input  1  downstream accepts the word this cycle

Behaviour:
- Reset (iRst_n=0, asynchronous, any time):
  - oValid=0, oZ=0, oS1=0, oS0=0.
  - Round-robin pointer ptr=0, state IDLE.
  - oReady=4'b0000 while in reset.
  - Reset mid-transfer discards the held word; no grant is issued in the reset cycle.
- States: IDLE (holding register empty, oValid=0) and HOLD (holding register full, oValid=1).
- Slot free = (state==IDLE) or (oValid and iReady).
- Arbitration (combinational): when the slot is free and iValid!=0, grant the first set bit of iValid scanning ptr, ptr+1, ... mod 4.
  - Wrap 3->0.
  - oReady is one-hot on that bit; otherwise oReady=0.
  - At most one oReady bit is ever high.
- Load (on the clock edge with a grant k):
  - oZ<=iDk, {oS1,oS0}<=k[1:0], oValid<=1, state<=HOLD.
  - ptr<=(k+1) mod 4.
- No grant and oValid&iReady: oValid<=0, state<=IDLE; oZ/oS keep their last value.
- Stall (oValid=1, iReady=0): oZ, oS1, oS0 and oValid stable; oReady=0; ptr unchanged.
- Latency: 1 cycle from a channel handshake (iValid[k]&oReady[k]) to oValid=1 with that word.
- Throughput: 1 word/cycle. Simultaneous accept and new grant in the same cycle reloads with no bubble; oValid stays 1.
- Fairness: with all four channels requesting continuously and iReady=1, the output sequence is 0,1,2,3,0,... Each channel waits at most 3 words.
- iValid deasserted before a grant: that request is dropped with no effect.
- iD sampled only on the grant edge.

Test Plan:
- Reset then idle: iRst_n pulse low 20 ns, iValid=0 -> oValid=0, oZ=0, {oS1,oS0}=00, oReady=0000 throughout.
- Single channel: iValid=0010, iD1=8'hA5, iReady=1 -> oReady=0010 one cycle; next cycle oZ=A5, {oS1,oS0}=01, oValid=1; then oValid=0 after the accept.
- Round robin with wrap: iValid=1111, iD0..3=11,22,33,44, iReady=1 for 6 cycles -> oZ sequence 11,22,33,44,11,22 with index 00,01,10,11,00,01; oValid continuously 1.
- Back-pressure: load iD2=8'h3C, hold iReady=0 for 5 cycles with iValid=1111 -> oZ=3C, index 10 stable, oReady=0000; on iReady=1 the next word is from channel 3 (index 11).
- Reset mid-operation: while oValid=1 with oZ=8'h44, drive iRst_n=0 asynchronously between edges -> oValid, oZ, oS1, oS0 drop to 0 immediately; after release with iValid=1111, the first grant is channel 0.
- Loopback: connect oZ/oS1/oS0 to the 1-to-4 de-selector (iC=oZ bit 0), sweep channels 0..3 -> the pulse appears only on the de-selector output matching the granted channel.
